pixel_cfg_shifter: RTL and testbench
====================================

Name: pixel_cfg_shifter

Overview:
- Serializes pixel-configuration frames into the pixel chip's config shift chain.
- Clocked by the divided slow configuration clock (clkin), which is produced by the upstream odd-ratio 50%-duty divider in pixel_config.
- Takes parallel words from the config FIFO via a valid/ready handshake.
- Drives serial data, a shift-clock enable and a load strobe to the chip.

Parameters:
- WORD_W, 8, bits per input word; must be ≥2.
- FRAME_WORDS, 4, words per frame; must be ≥1.
- LOAD_GAP, 1, idle cycles between the last bit and the load strobe; 0 allowed.
- LOAD_LEN, 2, cycles sload is held high; must be ≥1.

Ports:
- clkin  in  1  slow config clock.
- rst  in  1  synchronous, active-low reset.
- start  in  1  frame request pulse; sampled only in IDLE.
- in_data  in  WORD_W  config word, sent MSB first.
- in_valid  in  1  in_data valid.
- in_ready  out  1  word accepted on a clkin edge when in_valid & in_ready.
- sdo  out  1  serial data to the chip, registered.
- sclk_en  out  1  chip shift-clock gate; high exactly in cycles carrying a valid sdo bit.
- sload  out  1  chip latch strobe.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the frame completes.

Behaviour:
- Reset (rst=0 at a clkin edge): state IDLE; sdo, sclk_en, sload, in_ready, done = 0; bit counter, word counter and shift register cleared.
  - Reset mid-frame aborts immediately; no sload is issued and no done pulse occurs.
- States: IDLE, SHIFT, GAP, LOAD, FIN.
- IDLE:
  - in_ready=0.
  - start=1 → SHIFT, words_left=FRAME_WORDS.
  - start is ignored in all other states.
- SHIFT:
  - in_ready=1 when the shift register is empty, or on the last bit of the current word while words_left>0.
  - On acceptance at edge k:
    - shift register loads in_data;
    - from cycle k+1, sdo=in_data[WORD_W-1] and sclk_en=1;
    - each following cycle shifts left one bit.
  - Back-to-back valid words give a gapless bit stream: WORD_W×FRAME_WORDS consecutive sclk_en cycles.
  - If in_valid=0 when a word is needed: stall with sclk_en=0 and sdo held at its last value; no bits are counted; no timeout.
  - After the last bit of the last word: → GAP, or → LOAD directly if LOAD_GAP=0.
- GAP: sclk_en=0 for LOAD_GAP cycles, then → LOAD.
- LOAD: sload=1 for LOAD_LEN cycles, then → FIN.
- FIN: done=1 for one cycle, then → IDLE. busy falls in the same cycle.
- Latency, ideal input (start at edge 0, words ready):
  - first word accepted at edge 1;
  - first sdo bit in cycle 2;
  - sload rises WORD_W×FRAME_WORDS + LOAD_GAP cycles after the first bit.
- Counters are sized as clog2 of their ranges. Neither counter wraps; both are cleared on entering IDLE.
- in_valid during IDLE, GAP, LOAD or FIN is ignored (in_ready=0).

Optional Feature:
- Macro PIXCFG_READBACK_EN.
- When defined:
  - adds input sdi (1 bit, chain output from the chip) and outputs rd_data[WORD_W-1:0] and rd_valid.
  - sdi is sampled on every sclk_en=1 cycle into a WORD_W shift register, MSB first.
  - rd_valid pulses one cycle after each WORD_W-th sampled bit; rd_data holds that word until the next pulse.
  - Reset clears both outputs.
- When undefined: the ports and the logic do not exist.

Decomposition:
- Shared package pixel_cfg_pkg holds:
  - the state enum (IDLE/SHIFT/GAP/LOAD/FIN);
  - default constants WORD_W, FRAME_WORDS, LOAD_GAP, LOAD_LEN.
- One natural sub-module, pixel_cfg_piso: a WORD_W parallel-in/serial-out register with load and shift enables.
  - Reused for readback as a SIPO configuration of the same shifter, under the macro.

Test Plan (WORD_W=8, FRAME_WORDS=2, LOAD_GAP=1, LOAD_LEN=2):
- Basic frame:
  - Stimulus: start; in_valid always high; words 0xA5, 0x3C.
  - Required: sdo=1010_0101_0011_1100 over 16 consecutive sclk_en cycles; one gap cycle; sload high 2 cycles; done pulses once; busy low afterwards.
- Input stall:
  - Stimulus: in_valid dropped for 3 cycles before the second word.
  - Required: sclk_en low exactly 3 cycles; sdo bit sequence unchanged; total sclk_en count = 16.
- Reset mid-frame:
  - Stimulus: rst=0 after 5 bits, then start a new frame.
  - Required: outputs 0 the cycle after the reset edge; no sload; no done; the new frame is bit-exact.
- Spurious start:
  - Stimulus: start pulses during SHIFT and LOAD.
  - Required: no effect; exactly one frame and one done.
- Edge parameters:
  - Stimulus: LOAD_GAP=0, FRAME_WORDS=1, word 0xFF.
  - Required: 8 ones on sdo; sload rises in the cycle after the last bit.
- Readback (PIXCFG_READBACK_EN):
  - Stimulus: sdi driven as sdo delayed 8 sclk_en cycles.
  - Required: rd_data=0xA5 with rd_valid after bit 16.

Source files
------------

// File: rtl/pixel_cfg_pkg.sv
// pixel_cfg_pkg: shared state encoding, default parameters
// and counter sizing helper for the pixel config shift chain.
package pixel_cfg_pkg;

  localparam int DEF_WORD_W      = 8;
  localparam int DEF_FRAME_WORDS = 4;
  localparam int DEF_LOAD_GAP    = 1;
  localparam int DEF_LOAD_LEN    = 2;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    GAP,
    LOAD,
    FIN
  } state_t;

  // width needed to hold the values 0 .. n-1
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pixel_cfg_piso.sv
// pixel_cfg_piso: W-bit shift register with parallel load,
// shifting left with si entering at the LSB.
module pixel_cfg_piso
  import pixel_cfg_pkg::*;
#(
  parameter int W = DEF_WORD_W
) (
  input  logic         clkin,
  input  logic         rst,
  input  logic         ld,
  input  logic         sh,
  input  logic         si,
  input  logic [W-1:0] din,
  output logic [W-1:0] q
);

  always_ff @(posedge clkin) begin
    if (!rst) begin
      q <= '0;
    end else if (ld) begin
      q <= din;
    end else if (sh) begin
      q <= {q[W-2:0], si};
    end
  end

endmodule

// File: rtl/pixel_cfg_shifter.sv
// pixel_cfg_shifter: frames FIFO words onto the chip config chain.
// Define PIXCFG_READBACK_EN to add the sdi readback path.
module pixel_cfg_shifter
  import pixel_cfg_pkg::*;
#(
  parameter int WORD_W      = DEF_WORD_W,
  parameter int FRAME_WORDS = DEF_FRAME_WORDS,
  parameter int LOAD_GAP    = DEF_LOAD_GAP,
  parameter int LOAD_LEN    = DEF_LOAD_LEN
) (
  input  logic              clkin,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              sdo,
  output logic              sclk_en,
  output logic              sload,
  output logic              busy,
  output logic              done
`ifdef PIXCFG_READBACK_EN
  ,
  input  logic              sdi,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid
`endif
);

  localparam int PMAX = (LOAD_GAP > LOAD_LEN) ? LOAD_GAP : LOAD_LEN;
  localparam int BW   = cnt_w(WORD_W + 1);
  localparam int WCW  = cnt_w(FRAME_WORDS + 1);
  localparam int PCW  = cnt_w(PMAX + 1);

  localparam logic [BW-1:0]  BITS_FULL = BW'(WORD_W);
  localparam logic [BW-1:0]  BITS_ONE  = BW'(1);
  localparam logic [WCW-1:0] WORDS_ALL = WCW'(FRAME_WORDS);
  localparam logic [PCW-1:0] GAP_END   =
    PCW'((LOAD_GAP > 0) ? LOAD_GAP - 1 : 0);
  localparam logic [PCW-1:0] LOAD_END  = PCW'(LOAD_LEN - 1);

  state_t            state;
  logic [BW-1:0]     bits_left;
  logic [WCW-1:0]    words_left;
  logic [PCW-1:0]    pcnt;
  logic [WORD_W-1:0] tx_q;
  logic              last_bit;
  logic              more;
  logic              accept;
  logic              tx_sh;
  logic              unused_tx;

  assign last_bit = (bits_left == BITS_ONE);
  assign more     = (words_left != '0);
  assign in_ready = (state == SHIFT) && more &&
                    ((bits_left == '0) || last_bit);
  assign accept   = in_ready && in_valid;
  // the last bit is never shifted out so a stall holds sdo
  assign tx_sh    = (state == SHIFT) && !accept &&
                    (bits_left > BITS_ONE);

  pixel_cfg_piso #(.W(WORD_W)) u_tx (
    .clkin (clkin),
    .rst   (rst),
    .ld    (accept),
    .sh    (tx_sh),
    .si    (1'b0),
    .din   (in_data),
    .q     (tx_q)
  );

  assign sdo       = tx_q[WORD_W-1];
  assign unused_tx = ^tx_q[WORD_W-2:0];

  always_ff @(posedge clkin) begin
    if (!rst) begin
      state      <= IDLE;
      bits_left  <= '0;
      words_left <= '0;
      pcnt       <= '0;
      sclk_en    <= 1'b0;
      sload      <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state      <= SHIFT;
            words_left <= WORDS_ALL;
            busy       <= 1'b1;
          end
        end
        SHIFT: begin
          sclk_en <= accept || (bits_left > BITS_ONE);
          if (accept) begin
            bits_left  <= BITS_FULL;
            words_left <= words_left - 1'b1;
          end else if (bits_left != '0) begin
            bits_left <= bits_left - 1'b1;
            if (last_bit && !more) begin
              if (LOAD_GAP == 0) begin
                state <= LOAD;
                sload <= 1'b1;
              end else begin
                state <= GAP;
              end
            end
          end
        end
        GAP: begin
          if (pcnt == GAP_END) begin
            pcnt  <= '0;
            state <= LOAD;
            sload <= 1'b1;
          end else begin
            pcnt <= pcnt + 1'b1;
          end
        end
        LOAD: begin
          if (pcnt == LOAD_END) begin
            pcnt  <= '0;
            state <= FIN;
            sload <= 1'b0;
            done  <= 1'b1;
          end else begin
            pcnt <= pcnt + 1'b1;
          end
        end
        FIN: begin
          state      <= IDLE;
          done       <= 1'b0;
          busy       <= 1'b0;
          bits_left  <= '0;
          words_left <= '0;
          pcnt       <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PIXCFG_READBACK_EN
  localparam int RCW = cnt_w(WORD_W);
  localparam logic [RCW-1:0] RD_LAST = RCW'(WORD_W - 1);

  logic [WORD_W-1:0] rx_q;
  logic [RCW-1:0]    rd_cnt;
  logic              unused_rx;

  pixel_cfg_piso #(.W(WORD_W)) u_rx (
    .clkin (clkin),
    .rst   (rst),
    .ld    (1'b0),
    .sh    (sclk_en),
    .si    (sdi),
    .din   ('0),
    .q     (rx_q)
  );

  assign unused_rx = rx_q[WORD_W-1];

  always_ff @(posedge clkin) begin
    if (!rst) begin
      rd_cnt   <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (sclk_en) begin
        if (rd_cnt == RD_LAST) begin
          rd_cnt   <= '0;
          rd_valid <= 1'b1;
          rd_data  <= {rx_q[WORD_W-2:0], sdi};
        end else begin
          rd_cnt <= rd_cnt + 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_pixel_cfg_shifter.sv
// tb_pixel_cfg_shifter: scoreboard bench, two instances
// (2 words/gap 1 and 1 word/gap 0), optional readback.
module tb_pixel_cfg_shifter;

  typedef struct {
    int bits;
    int stalls;
  } frame_t;

  logic            clkin;
  logic            rst;
  logic [1:0]      start;
  logic [1:0]      in_valid;
  logic [1:0][7:0] in_data;
  logic [1:0]      in_ready;
  logic [1:0]      sdo;
  logic [1:0]      sclk_en;
  logic [1:0]      sload;
  logic [1:0]      busy;
  logic [1:0]      done;

  bit     exp_bits [2][$];
  frame_t exp_frames [2][$];
  int     bitcnt [2];
  int     stalls [2];
  int     done_cnt [2];
  int     checks;
  int     errors;

`ifdef PIXCFG_READBACK_EN
  logic [1:0][7:0] rd_data;
  logic [1:0]      rd_valid;
  logic [7:0]      hist;
  logic [7:0]      exp_rd [$];

  always @(posedge clkin) begin
    if (!rst) hist <= '0;
    else if (sclk_en[0]) hist <= {hist[6:0], sdo[0]};
  end
`endif

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : dut
    localparam int FW = (g == 0) ? 2 : 1;
    localparam int LG = (g == 0) ? 1 : 0;

    pixel_cfg_shifter #(
      .WORD_W      (8),
      .FRAME_WORDS (FW),
      .LOAD_GAP    (LG),
      .LOAD_LEN    (2)
    ) u_dut (
      .clkin    (clkin),
      .rst      (rst),
      .start    (start[g]),
      .in_data  (in_data[g]),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .sdo      (sdo[g]),
      .sclk_en  (sclk_en[g]),
      .sload    (sload[g]),
      .busy     (busy[g]),
      .done     (done[g])
`ifdef PIXCFG_READBACK_EN
      ,
      .sdi      ((g == 0) ? hist[7] : 1'b0),
      .rd_data  (rd_data[g]),
      .rd_valid (rd_valid[g])
`endif
    );

    initial begin : mon
      int cyc, last_bit, sl_len;
      bit sl_q, dn_q, b;
      frame_t f;
      cyc = 0;
      last_bit = 0;
      sl_len = 0;
      sl_q = 0;
      dn_q = 0;
      forever begin
        @(negedge clkin);
        cyc++;
        if (!rst) begin
          bitcnt[g] = 0;
          stalls[g] = 0;
          sl_len = 0;
          sl_q = 0;
          dn_q = 0;
        end else begin
          if (sclk_en[g]) begin
            if (exp_bits[g].size() == 0) begin
              check("extra_bit", int'(sclk_en[g]), 0);
            end else begin
              b = exp_bits[g].pop_front();
              check("sdo", int'(sdo[g]), int'(b));
            end
            bitcnt[g]++;
            last_bit = cyc;
          end else if (busy[g] && bitcnt[g] > 0 &&
                       exp_bits[g].size() > 0) begin
            stalls[g]++;
          end
          if (sload[g] && !sl_q) begin
            check("sload_spurious",
                  int'(exp_frames[g].size() == 0), 0);
            check("sload_latency", cyc - last_bit, LG + 1);
          end
          if (sload[g]) sl_len++;
          else if (sl_q) begin
            check("sload_len", sl_len, 2);
            sl_len = 0;
          end
          if (dn_q) check("busy_after_done", int'(busy[g]), 0);
          if (done[g]) begin
            check("done_width", int'(dn_q), 0);
            if (exp_frames[g].size() == 0) begin
              check("done_spurious", int'(done[g]), 0);
            end else begin
              f = exp_frames[g].pop_front();
              check("frame_bits", bitcnt[g], f.bits);
              check("frame_stalls", stalls[g], f.stalls);
            end
            bitcnt[g] = 0;
            stalls[g] = 0;
            done_cnt[g]++;
          end
          sl_q = sload[g];
          dn_q = done[g];
        end
      end
    end
  end

`ifdef PIXCFG_READBACK_EN
  initial begin : rd_mon
    forever begin
      @(negedge clkin);
      if (rst && rd_valid[0] && exp_rd.size() > 0)
        check("rd_data", int'(rd_data[0]), int'(exp_rd.pop_front()));
    end
  end
`endif

  initial begin
    clkin = 1'b0;
    forever #5 clkin = ~clkin;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic start_frame(input int d, input int bits, input int st);
    frame_t f;
    f.bits = bits;
    f.stalls = st;
    exp_frames[d].push_back(f);
    pulse_start(d);
  endtask

  task automatic pulse_start(input int d);
    @(negedge clkin);
    start[d] = 1'b1;
    @(posedge clkin);
    #1 start[d] = 1'b0;
  endtask

  task automatic send_word(input int d, input logic [7:0] w, input int st);
    int t;
    for (int i = 7; i >= 0; i--) exp_bits[d].push_back(w[i]);
    in_data[d] = w;
    in_valid[d] = 1'b0;
    t = 0;
    forever begin
      @(negedge clkin);
      t++;
      if (t > 300) begin
        check("accept_timeout", int'(in_ready[d]), 1);
        return;
      end
      if (in_ready[d]) begin
        if (st == 0) break;
        st--;
      end
    end
    in_valid[d] = 1'b1;
    @(posedge clkin);
    #1 in_valid[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    int t;
    t = 0;
    do begin
      @(posedge clkin);
      #2 t++;
    end while (busy[d] && t < 300);
    check("idle_timeout", int'(busy[d]), 0);
  endtask

  task automatic check_quiet(input string name, input int d);
    check(name, int'({sdo[d], sclk_en[d], sload[d],
                      in_ready[d], done[d], busy[d]}), 0);
  endtask

  initial begin
    int t, dc;
    checks = 0;
    errors = 0;
    rst = 1'b0;
    start = '0;
    in_valid = '0;
    in_data = '0;
    repeat (3) @(posedge clkin);
    @(negedge clkin);
    check_quiet("reset_state0", 0);
    check_quiet("reset_state1", 1);
    @(posedge clkin);
    #1 rst = 1'b1;

    // basic frame
    start_frame(0, 16, 0);
    send_word(0, 8'hA5, 0);
    send_word(0, 8'h3C, 0);
    wait_idle(0);

    // stall of three cycles before the second word
    start_frame(0, 16, 3);
    send_word(0, 8'hA5, 0);
    send_word(0, 8'h3C, 3);
    wait_idle(0);

    // reset after five bits
    dc = done_cnt[0];
    start_frame(0, 16, 0);
    send_word(0, 8'h96, 0);
    t = 0;
    do begin
      @(posedge clkin);
      #2 t++;
    end while (bitcnt[0] < 5 && t < 100);
    check("bits_before_reset", bitcnt[0], 5);
    rst = 1'b0;
    @(posedge clkin);
    #1 exp_bits[0].delete();
    exp_frames[0].delete();
    @(negedge clkin);
    check_quiet("mid_reset_outputs", 0);
    @(posedge clkin);
    #1 rst = 1'b1;
    repeat (6) @(posedge clkin);
    #2 check("no_done_after_abort", done_cnt[0], dc);
    start_frame(0, 16, 0);
    send_word(0, 8'hA5, 0);
    send_word(0, 8'h3C, 0);
    wait_idle(0);

    // spurious start in SHIFT and LOAD
    dc = done_cnt[0];
    start_frame(0, 16, 0);
    send_word(0, 8'h5A, 0);
    pulse_start(0);
    send_word(0, 8'hC3, 0);
    t = 0;
    do begin
      @(posedge clkin);
      #2 t++;
    end while (!sload[0] && t < 100);
    check("sload_seen", int'(sload[0]), 1);
    pulse_start(0);
    wait_idle(0);
    repeat (5) @(posedge clkin);
    #2 check("spurious_idle", int'(busy[0]), 0);
    check("spurious_one_done", done_cnt[0] - dc, 1);

    // one-word frame, no gap, all ones
    start_frame(1, 8, 0);
    send_word(1, 8'hFF, 0);
    wait_idle(1);
    check("edge_done", done_cnt[1], 1);

`ifdef PIXCFG_READBACK_EN
    @(negedge clkin);
    rst = 1'b0;
    @(posedge clkin);
    #1 rst = 1'b1;
    exp_rd.push_back(8'h00);
    exp_rd.push_back(8'hA5);
    start_frame(0, 16, 0);
    send_word(0, 8'hA5, 0);
    send_word(0, 8'h3C, 0);
    wait_idle(0);
    check("rd_pending", exp_rd.size(), 0);
    check("total_done0", done_cnt[0], 5);
`else
    check("total_done0", done_cnt[0], 4);
`endif

    check("bits_left0", exp_bits[0].size(), 0);
    check("bits_left1", exp_bits[1].size(), 0);
    check("frames_left0", exp_frames[0].size(), 0);
    check("frames_left1", exp_frames[1].size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
